axis_jtag_multi: RTL and testbench

//  Multi-channel AXIS-to-JTAG shift engine: each AXIS word carries TMS/TDI vectors and a bit count.

---
 rtl/axis_jtag_multi_if.sv | 12 +
 rtl/axis_jtag_multi.sv | 127 ++++++++++++
 tb/tb_axis_jtag_multi.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_jtag_multi_if.sv
// axis_jtag_multi_if: AXI-Stream bundle used for the shift engine's command and result streams
interface axis_jtag_multi_if #(
    parameter int DW = 64,
    parameter int UW = 5
) ();
    logic [DW-1:0] tdata;
    logic [UW-1:0] tuser;
    logic          tvalid;
    logic          tready;
    modport master (output tdata, tuser, tvalid, input tready);
    modport slave  (input tdata, tuser, tvalid, output tready);
endinterface

// File: rtl/axis_jtag_multi.sv
// axis_jtag_multi: AXIS-driven multi-port JTAG shifter with TDO capture and result stream
module axis_jtag_multi #(
    parameter int C_NUM_CHANNELS    = 4,
    parameter int C_VEC_WIDTH       = 32,
    parameter int C_TCK_CLOCK_RATIO = 8,
    localparam int CHW = C_NUM_CHANNELS > 1 ? $clog2(C_NUM_CHANNELS) : 1,
    localparam int LW  = C_VEC_WIDTH > 1 ? $clog2(C_VEC_WIDTH) : 1
) (
    input  logic                      s_axis_aclk,
    input  logic                      s_axis_aresetn,
    input  logic [CHW-1:0]            channel,
    axis_jtag_multi_if.slave          s_axis,
    axis_jtag_multi_if.master         m_axis,
    output logic [C_NUM_CHANNELS-1:0] tck,
    output logic [C_NUM_CHANNELS-1:0] tms,
    output logic [C_NUM_CHANNELS-1:0] tdi,
    input  logic [C_NUM_CHANNELS-1:0] tdo,
    output logic                      busy
);
    localparam int H  = C_TCK_CLOCK_RATIO / 2;
    localparam int DW = H > 1 ? $clog2(H) : 1;
    localparam int V  = C_VEC_WIDTH;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;

    state_t                      state;
    logic [DW-1:0]               cnt;
    logic [LW-1:0]               idx;
    logic [LW-1:0]               last;
    logic [V-1:0]                tms_v;
    logic [V-1:0]                tdi_v;
    logic [V-1:0]                res;
    logic [CHW-1:0]              ch;
    logic                        tck_r;
    logic                        tms_r;
    logic                        tdi_r;
    logic                        mvalid;
    logic                        rdy;
    logic [C_NUM_CHANNELS-1:0]   sel;
    logic                        div_end;
    logic                        tdo_bit;

    // one-hot decode of the latched channel; an out-of-range channel selects nothing
    for (genvar g = 0; g < C_NUM_CHANNELS; g++) begin : g_sel
        assign sel[g] = ch == CHW'(g);
    end

    assign div_end        = cnt == DW'(H - 1);
    assign tdo_bit        = |(tdo & sel);
    assign tck            = sel & {C_NUM_CHANNELS{tck_r}};
    assign tms            = sel & {C_NUM_CHANNELS{tms_r}};
    assign tdi            = sel & {C_NUM_CHANNELS{tdi_r}};
    assign busy           = state != IDLE;
    assign s_axis.tready  = rdy;
    assign m_axis.tvalid  = mvalid;
    assign m_axis.tdata   = res;
    assign m_axis.tuser   = '0;

    // shift FSM: half-period divider, LSB-first drive on falling tck, capture on rising tck
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            last   <= '0;
            tms_v  <= '0;
            tdi_v  <= '0;
            res    <= '0;
            ch     <= '0;
            tck_r  <= 1'b0;
            tms_r  <= 1'b0;
            tdi_r  <= 1'b0;
            mvalid <= 1'b0;
            rdy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rdy <= !(s_axis.tvalid && rdy);
                    if (s_axis.tvalid && rdy) begin
                        tms_v <= s_axis.tdata[2*V-1:V];
                        tdi_v <= s_axis.tdata[V-1:0];
                        tms_r <= s_axis.tdata[V];
                        tdi_r <= s_axis.tdata[0];
                        last  <= s_axis.tuser;
                        ch    <= channel;
                        cnt   <= '0;
                        idx   <= '0;
                        res   <= '0;
                        state <= LOW;
                    end
                end
                LOW: begin
                    cnt <= div_end ? '0 : cnt + 1'b1;
                    if (div_end) begin
                        tck_r    <= 1'b1;
                        res[idx] <= tdo_bit;
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    cnt <= div_end ? '0 : cnt + 1'b1;
                    if (div_end) begin
                        tck_r <= 1'b0;
                        if (idx == last) begin
                            mvalid <= 1'b1;
                            state  <= RESP;
                        end else begin
                            idx   <= idx + 1'b1;
                            tms_v <= tms_v >> 1;
                            tdi_v <= tdi_v >> 1;
                            tms_r <= tms_v[1];
                            tdi_r <= tdi_v[1];
                            state <= LOW;
                        end
                    end
                end
                default: begin
                    if (m_axis.tready) begin
                        mvalid <= 1'b0;
                        rdy    <= 1'b1;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axis_jtag_multi.sv
// tb_axis_jtag_multi: directed self-checking bench for the multi-port JTAG shifter
module tb_axis_jtag_multi;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [1:0] channel = 0;
    logic       lb = 1;
    logic [3:0] tdo_val = 0;
    logic [3:0] tck, tms, tdi;
    logic [3:0] tdo;
    logic       busy;
    assign tdo = lb ? tdi : tdo_val;

    axis_jtag_multi_if #(.DW(64), .UW(5)) s_if ();
    axis_jtag_multi_if #(.DW(32), .UW(1)) m_if ();

    axis_jtag_multi #(.C_NUM_CHANNELS(4), .C_VEC_WIDTH(32), .C_TCK_CLOCK_RATIO(8)) dut (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .channel(channel),
        .s_axis(s_if), .m_axis(m_if),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
    );

    logic [2:0] ch6 = 0;
    logic [5:0] tck6, tms6, tdi6;
    logic       busy6;
    axis_jtag_multi_if #(.DW(64), .UW(5)) s6_if ();
    axis_jtag_multi_if #(.DW(32), .UW(1)) m6_if ();

    axis_jtag_multi #(.C_NUM_CHANNELS(6), .C_VEC_WIDTH(32), .C_TCK_CLOCK_RATIO(8)) dut6 (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .channel(ch6),
        .s_axis(s6_if), .m_axis(m6_if),
        .tck(tck6), .tms(tms6), .tdi(tdi6), .tdo(tdi6), .busy(busy6)
    );

    // port activity monitor for the 4-channel instance
    int          pulses[4];
    logic [3:0]  act = 0;
    logic [3:0]  tck_q = 0;
    logic [31:0] seq_tdi = 0;
    logic [31:0] seq_tms = 0;
    int          last_rise = -1;
    logic        per_bad = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (tck[i] && !tck_q[i]) pulses[i]++;
        if (tck[0] && !tck_q[0]) begin
            if (pulses[0] <= 32) begin
                seq_tdi[pulses[0]-1] = tdi[0];
                seq_tms[pulses[0]-1] = tms[0];
            end
            if (last_rise >= 0 && cyc - last_rise != 8) per_bad = 1;
            last_rise = cyc;
        end
        act = act | tck | tms | tdi;
        tck_q = tck;
    end

    task automatic clear_mon();
        #1;
        for (int i = 0; i < 4; i++) pulses[i] = 0;
        act = 0;
        seq_tdi = 0;
        seq_tms = 0;
        last_rise = -1;
        per_bad = 0;
    endtask

    // present a word and return at the falling edge right after it is accepted
    task automatic send(input logic [31:0] d, input logic [31:0] m, input logic [4:0] n, input logic [1:0] c);
        int w = 0;
        @(negedge clk);
        s_if.tdata = {m, d};
        s_if.tuser = n;
        channel = c;
        s_if.tvalid = 1;
        while (!s_if.tready && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!s_if.tready) begin
            errors++;
            $display("FAIL accept_timeout tready=%b want 1", s_if.tready);
        end
        @(posedge clk);
        @(negedge clk);
        s_if.tvalid = 0;
    endtask

    // lat counts clocks from the accept edge (0 at the falling edge right after it)
    task automatic wait_res(output logic [31:0] d, output int lat);
        lat = 0;
        while (!m_if.tvalid && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        d = m_if.tdata;
    endtask

    task automatic take();
        @(negedge clk);
        m_if.tready = 1;
        @(negedge clk);
        m_if.tready = 0;
        checks++;
        if (s_if.tready !== 1'b1 || m_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL post_handshake tready=%b tvalid=%b want 1 0", s_if.tready, m_if.tvalid);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", s_if.tready); end
        checks++;
        if (m_if.tvalid !== 1'b0 || m_if.tdata !== 32'h0) begin
            errors++; $display("FAIL rst_result tvalid=%b tdata=%h want 0 0", m_if.tvalid, m_if.tdata);
        end
        checks++;
        if ({busy, tck, tms, tdi} !== 13'h0) begin
            errors++; $display("FAIL rst_jtag busy=%b tck=%b tms=%b tdi=%b want all 0", busy, tck, tms, tdi);
        end
        rst_n = 1;
        #1;
        checks++;
        if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rel_tready got %b want 0", s_if.tready); end
        @(negedge clk);
        checks++;
        if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rel_tready1 got %b want 1", s_if.tready); end
    endtask

    task automatic test_loopback();
        logic [31:0] d;
        int lat;
        lb = 1;
        clear_mon();
        send(32'hA5, 32'h0, 5'd7, 2'd0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL lb_busy got %b want 1", busy); end
        wait_res(d, lat);
        checks++;
        if (d !== 32'h000000A5) begin errors++; $display("FAIL lb_data got %h want 000000a5", d); end
        checks++;
        if (lat != 64) begin errors++; $display("FAIL lb_latency got %0d want 64", lat); end
        checks++;
        if (pulses[0] != 8 || seq_tdi[7:0] !== 8'hA5) begin
            errors++; $display("FAIL lb_pulses got %0d seq %h want 8 a5", pulses[0], seq_tdi[7:0]);
        end
        checks++;
        if (per_bad !== 1'b0) begin errors++; $display("FAIL lb_period got bad=%b want 0", per_bad); end
        checks++;
        if (act[3:1] !== 3'b000) begin errors++; $display("FAIL lb_idle_ports got %b want 000", act[3:1]); end
        take();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int lat;
        int p;
        lb = 1;
        clear_mon();
        send(32'h3C, 32'h0, 5'd7, 2'd0);
        wait_res(d, lat);
        checks++;
        if (d !== 32'h3C) begin errors++; $display("FAIL b2b_first got %h want 0000003c", d); end
        p = pulses[0];
        fork
            send(32'h81, 32'h0, 5'd7, 2'd0);
        join_none
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h3C || s_if.tready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_hold tvalid=%b tdata=%h tready=%b busy=%b want 1 3c 0 1",
                         m_if.tvalid, m_if.tdata, s_if.tready, busy);
            end
        end
        checks++;
        if (pulses[0] != p) begin errors++; $display("FAIL b2b_no_tck got %0d want %0d", pulses[0], p); end
        take();
        wait_res(d, lat);
        checks++;
        if (d !== 32'h81 || lat != 65) begin
            errors++; $display("FAIL b2b_second got %h lat %0d want 00000081 65", d, lat);
        end
        take();
    endtask

    task automatic test_channel_switch();
        logic [31:0] d;
        int lat;
        lb = 1;
        clear_mon();
        send(32'hC3, 32'h0, 5'd7, 2'd2);
        repeat (24) @(negedge clk);
        channel = 2'd1;
        wait_res(d, lat);
        checks++;
        if (d !== 32'hC3) begin errors++; $display("FAIL sw_data got %h want 000000c3", d); end
        checks++;
        if (pulses[2] != 8) begin errors++; $display("FAIL sw_pulses2 got %0d want 8", pulses[2]); end
        checks++;
        if (act[1] !== 1'b0 || act[3] !== 1'b0 || pulses[0] != 0) begin
            errors++; $display("FAIL sw_idle act1=%b act3=%b p0=%0d want 0 0 0", act[1], act[3], pulses[0]);
        end
        take();
    endtask

    task automatic test_full();
        logic [31:0] d;
        int lat;
        lb = 0;
        tdo_val = 4'hF;
        clear_mon();
        send(32'hFFFFFFFF, 32'h12345678, 5'd31, 2'd0);
        wait_res(d, lat);
        checks++;
        if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL full_data got %h want ffffffff", d); end
        checks++;
        if (lat != 256) begin errors++; $display("FAIL full_latency got %0d want 256", lat); end
        checks++;
        if (pulses[0] != 32 || seq_tms !== 32'h12345678 || seq_tdi !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL full_seq pulses %0d tms %h tdi %h want 32 12345678 ffffffff",
                               pulses[0], seq_tms, seq_tdi);
        end
        take();
    endtask

    task automatic test_short();
        logic [31:0] d;
        int lat;
        lb = 0;
        tdo_val = 4'h0;
        send(32'h1, 32'h0, 5'd0, 2'd0);
        wait_res(d, lat);
        checks++;
        if (d !== 32'h0 || lat != 8) begin errors++; $display("FAIL one_bit0 got %h lat %0d want 0 8", d, lat); end
        take();
        tdo_val = 4'h1;
        send(32'h0, 32'h0, 5'd0, 2'd0);
        wait_res(d, lat);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL one_bit1 got %h want 00000001", d); end
        take();
        lb = 1;
        send(32'hFF, 32'h0, 5'd3, 2'd0);
        wait_res(d, lat);
        checks++;
        if (d !== 32'h0F || lat != 32) begin errors++; $display("FAIL upper_zero got %h lat %0d want 0000000f 32", d, lat); end
        take();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int lat;
        lb = 1;
        send(32'hA5, 32'hFF, 5'd7, 2'd0);
        repeat (42) @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({tck, tms, tdi} !== 12'h0 || m_if.tvalid !== 1'b0 || busy !== 1'b0 || s_if.tready !== 1'b0) begin
            errors++; $display("FAIL mid_reset tck=%b tms=%b tdi=%b tvalid=%b busy=%b want all 0",
                               tck, tms, tdi, m_if.tvalid, busy);
        end
        @(negedge clk);
        rst_n = 1;
        clear_mon();
        send(32'h5A, 32'h0, 5'd7, 2'd0);
        wait_res(d, lat);
        checks++;
        if (d !== 32'h5A || lat != 64) begin errors++; $display("FAIL mid_resume got %h lat %0d want 0000005a 64", d, lat); end
        checks++;
        if (pulses[0] != 8 || seq_tdi[7:0] !== 8'h5A) begin
            errors++; $display("FAIL mid_seq got %0d %h want 8 5a", pulses[0], seq_tdi[7:0]);
        end
        take();
    endtask

    task automatic run6(input logic [2:0] c, input logic [31:0] d, input logic [31:0] exp, input int exp_p,
                        input logic [5:0] mask);
        int lat = 0;
        int p = 0;
        int w = 0;
        logic [5:0] q;
        logic [5:0] a;
        @(negedge clk);
        s6_if.tdata = {32'h0, d};
        s6_if.tuser = 5'd7;
        ch6 = c;
        s6_if.tvalid = 1;
        while (!s6_if.tready && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        s6_if.tvalid = 0;
        ch6 = c ^ 3'd1;
        q = tck6;
        a = tck6 | tms6 | tdi6;
        while (!m6_if.tvalid && lat < 3000) begin
            @(negedge clk);
            lat++;
            p += $countones(tck6 & ~q);
            a = a | tck6 | tms6 | tdi6;
            q = tck6;
        end
        checks++;
        if (m6_if.tdata !== exp || lat != 64) begin
            errors++; $display("FAIL ch%0d_result got %h lat %0d want %h 64", c, m6_if.tdata, lat, exp);
        end
        checks++;
        if (p != exp_p || (a & mask) !== 6'h0) begin
            errors++; $display("FAIL ch%0d_ports pulses %0d act %b want %0d and no activity under %b",
                               c, p, a, exp_p, mask);
        end
        @(negedge clk);
        m6_if.tready = 1;
        @(negedge clk);
        m6_if.tready = 0;
    endtask

    task automatic test_six();
        run6(3'd5, 32'h96, 32'h96, 8, 6'b011111);
        run6(3'd7, 32'hFF, 32'h0, 0, 6'b111111);
        run6(3'd6, 32'h55, 32'h0, 0, 6'b111111);
    endtask

    initial begin
        s_if.tvalid = 0;
        s_if.tdata = 0;
        s_if.tuser = 0;
        m_if.tready = 0;
        s6_if.tvalid = 0;
        s6_if.tdata = 0;
        s6_if.tuser = 0;
        m6_if.tready = 0;
        for (int i = 0; i < 4; i++) pulses[i] = 0;
        test_reset();
        test_loopback();
        test_back_to_back();
        test_channel_switch();
        test_full();
        test_short();
        test_reset_mid();
        test_six();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
